// File: rtl/mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mealy_fsm
// Purpose  : Mealy sequence monitor; pulses aout on every MODULUS-th ain=1.
//            Optional hit counter enabled by defining MEALY_HIT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_fsm #(
    parameter int MODULUS = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ain,
    output logic             aout,
    output logic [CNT_W-1:0] state
`ifdef MEALY_HIT_CNT_EN
    ,
    output logic [7:0]       hit_cnt,
    output logic             hit_sat
`endif
);

    localparam logic [CNT_W-1:0] c_S0    = '0;
    localparam logic [CNT_W-1:0] c_SLAST = CNT_W'(MODULUS - 1);
    localparam logic [CNT_W:0]   c_MOD   = (CNT_W + 1)'(MODULUS);

    logic [CNT_W-1:0] r_state;
    logic [CNT_W-1:0] w_state_nxt;
    logic             w_legal;
    logic             w_hit;

    // Extra bit keeps the legality compare exact when MODULUS == 2^CNT_W.
    assign w_legal = ({1'b0, r_state} < c_MOD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        if (!w_legal) begin
            w_state_nxt = c_S0;
        end else if (ain) begin
            if (r_state == c_SLAST) begin
                w_state_nxt = c_S0;
                w_hit       = 1'b1;
            end else begin
                w_state_nxt = r_state + CNT_W'(1);
            end
        end
    end

    assign aout  = w_hit & ~reset;
    assign state = r_state;

`ifdef MEALY_HIT_CNT_EN
    logic [7:0] r_hit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= 8'd0;
        end else if (aout && (r_hit_cnt != 8'hFF)) begin
            r_hit_cnt <= r_hit_cnt + 8'd1;
        end
    end

    assign hit_cnt = r_hit_cnt;
    assign hit_sat = (r_hit_cnt == 8'hFF);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_fsm
// Purpose  : Scoreboard bench for mealy_fsm (MODULUS=3 and MODULUS=5 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_fsm;

    typedef struct packed {
        logic       a3;
        logic       a5;
    } aout_exp_t;

    typedef struct packed {
        logic [3:0] s3;
        logic [3:0] s5;
    } state_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ain3;
    logic       ain5;
    logic       aout3;
    logic       aout5;
    logic [3:0] state3;
    logic [3:0] state5;

    aout_exp_t  aq[$];
    state_exp_t sq[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef MEALY_HIT_CNT_EN
    logic [7:0] hit_cnt3;
    logic       hit_sat3;
    logic [7:0] hit_cnt5;
    logic       hit_sat5;
`endif

    always #5 clk = ~clk;

    mealy_fsm #(.MODULUS(3), .CNT_W(4)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .ain    (ain3),
        .aout   (aout3),
        .state  (state3)
`ifdef MEALY_HIT_CNT_EN
        ,
        .hit_cnt(hit_cnt3),
        .hit_sat(hit_sat3)
`endif
    );

    mealy_fsm #(.MODULUS(5), .CNT_W(4)) u_dut5 (
        .clk    (clk),
        .reset  (reset),
        .ain    (ain5),
        .aout   (aout5),
        .state  (state5)
`ifdef MEALY_HIT_CNT_EN
        ,
        .hit_cnt(hit_cnt5),
        .hit_sat(hit_sat5)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; expectations describe that cycle.
    task automatic step(input logic r, input logic a3, input logic a5,
                        input logic ea3, input logic [3:0] es3,
                        input logic ea5, input logic [3:0] es5);
        @(posedge clk);
        #1;
        reset = r;
        ain3  = a3;
        ain5  = a5;
        aq.push_back('{a3: ea3, a5: ea5});
        sq.push_back('{s3: es3, s5: es5});
    endtask

    // Mid-cycle check of the combinational output.
    always begin
        aout_exp_t e;
        @(negedge clk);
        if (aq.size() > 0) begin
            e = aq.pop_front();
            chk("aout_m3", int'(aout3), int'(e.a3));
            chk("aout_m5", int'(aout5), int'(e.a5));
        end
    end

    // Registered state check just after each edge.
    always begin
        state_exp_t e;
        @(posedge clk);
        #2;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("state_m3", int'(state3), int'(e.s3));
            chk("state_m5", int'(state5), int'(e.s5));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ain3  = 1'b0;
        ain5  = 1'b0;
        sq.push_back('{s3: 4'd0, s5: 4'd0});   // state after the first edge

        // Reset with ain=1: aout must stay low
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Continuous ones, MODULUS=3
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 2, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 2, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);

        // Gaps: 1,0,1,0,0,1
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 2, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);

        // Mid-count reset with ain=1
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 2, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 2, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);

        // MODULUS=5 instance: 10 consecutive ones
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 2);
        step(0, 0, 1, 0, 0, 0, 3);
        step(0, 0, 1, 0, 0, 0, 4);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 2);
        step(0, 0, 1, 0, 0, 0, 3);
        step(0, 0, 1, 0, 0, 0, 4);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

`ifdef MEALY_HIT_CNT_EN
        // 780 ones give 260 hits; the counter must stop at 255
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 780; i++) begin
            step(0, 1, 0, ((i % 3) == 2), 4'((i + 1) % 3), 0, 0);
            if (i == 30) begin
                chk("hit_cnt_mid", int'(hit_cnt3), 10);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hit_cnt_sat", int'(hit_cnt3), 255);
        chk("hit_sat_hi", int'(hit_sat3), 1);
        chk("hit_cnt_idle5", int'(hit_cnt5), 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hit_cnt_clr", int'(hit_cnt3), 0);
        chk("hit_sat_clr", int'(hit_sat3), 0);
`endif

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", aq.size() + sq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
